// File: rtl/bus_responder_8088.sv
// bus_responder_8088
//
// Target-side endpoint for the 8088 multiplexed local bus. On ale it latches
// the 20-bit address ({a, ad}) and decodes it against an address window and
// the memory/I-O space select. A hit is turned into a single req/ack
// transaction on a simple backend port. Read data is returned on ad while
// rd_n is low. Writes are posted. One address phase that arrives while a
// write is still outstanding is held in a one-deep pending slot.
//
// Parameters
//   BASE      window base address, compared under MASK
//   MASK      decode mask; hit = ((addr & MASK) == BASE)
//   IO_SPACE  iom value this instance answers (0 = memory, 1 = I/O)
//   TIMEOUT   backend cycles before an unacked request is abandoned (>= 2)
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   a[11:0]    upper address a[19:8]
//   ad[7:0]    multiplexed address/data bus (inout)
//   ale        address latch enable
//   rd_n       read strobe, active-low
//   wr_n       write strobe, active-low
//   dtr        0 = read, 1 = write; valid with ale
//   iom        0 = memory, 1 = I/O
//   ready      0 = wait request to the CPU
//   mem_req    backend request, held until mem_ack or timeout
//   mem_we     1 = write request
//   mem_addr   latched byte address
//   mem_wdata  write data
//   mem_rdata  read data, valid with mem_ack
//   mem_ack    backend completion, one cycle
//   timeout    one-cycle pulse when a request is abandoned

`timescale 1ns/1ps

module bus_responder_8088 #(
    parameter logic [19:0] BASE     = 20'h00000,
    parameter logic [19:0] MASK     = 20'hF0000,
    parameter logic        IO_SPACE = 1'b0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a,
    inout  wire  [7:0]  ad,
    input  logic        ale,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        dtr,
    input  logic        iom,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_WAIT,
        WR_REQ
    } state_t;

    state_t        state_q,      state_d;
    logic [19:0]   addr_q,       addr_d;
    logic [7:0]    wdata_q,      wdata_d;
    logic [7:0]    rdata_q,      rdata_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          seen_rd_q,    seen_rd_d;
    logic          timeout_q,    timeout_d;
    logic          pend_valid_q, pend_valid_d;
    logic [19:0]   pend_addr_q,  pend_addr_d;
    logic          pend_dtr_q,   pend_dtr_d;
    logic          pend_iom_q,   pend_iom_d;

    logic [19:0]   bus_addr;
    logic          in_req;
    logic          req_expire;
    logic          ad_oe;

    // Where an address phase leads: a hit needs both the window match and
    // the right address space; anything else is ignored.
    function automatic state_t decode(input logic [19:0] addr,
                                      input logic        is_wr,
                                      input logic        is_io);
        if (((addr & MASK) == BASE) && (is_io == IO_SPACE)) begin
            return is_wr ? WR_WAIT : RD_REQ;
        end
        return IDLE;
    endfunction

    assign bus_addr   = {a, ad};
    assign in_req     = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign req_expire = in_req && !mem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = '0;
        seen_rd_d    = 1'b0;
        timeout_d    = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_dtr_d   = pend_dtr_q;
        pend_iom_d   = pend_iom_q;

        case (state_q)
            IDLE: begin
                if (ale) begin
                    addr_d  = bus_addr;
                    state_d = decode(bus_addr, dtr, iom);
                end
            end

            RD_REQ: begin
                // rd_n normally falls while the backend is still working, so
                // the low phase is already tracked here.
                seen_rd_d = seen_rd_q | ~rd_n;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = RD_HOLD;
                end else if (req_expire) begin
                    rdata_d   = 8'hFF;
                    timeout_d = 1'b1;
                    state_d   = RD_HOLD;
                end
            end

            RD_HOLD: begin
                if (ale) begin
                    addr_d  = bus_addr;
                    state_d = decode(bus_addr, dtr, iom);
                end else if (rd_n && seen_rd_q) begin
                    state_d = IDLE;
                end else begin
                    seen_rd_d = seen_rd_q | ~rd_n;
                end
            end

            WR_WAIT: begin
                if (ale) begin
                    addr_d  = bus_addr;
                    state_d = decode(bus_addr, dtr, iom);
                end else if (!wr_n) begin
                    wdata_d = ad;
                    state_d = WR_REQ;
                end
            end

            WR_REQ: begin
                if (mem_ack || req_expire) begin
                    timeout_d    = req_expire;
                    pend_valid_d = 1'b0;
                    // An address phase in this very cycle is newer than
                    // anything in the pending slot.
                    if (ale) begin
                        addr_d  = bus_addr;
                        state_d = decode(bus_addr, dtr, iom);
                    end else if (pend_valid_q) begin
                        addr_d  = pend_addr_q;
                        state_d = decode(pend_addr_q, pend_dtr_q, pend_iom_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ale) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = bus_addr;
                    pend_dtr_d   = dtr;
                    pend_iom_d   = iom;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The counter only keeps running while the same request stays
        // outstanding; a WR_REQ -> RD_REQ hand-off restarts it at zero.
        if (in_req && (state_d == state_q)) begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            seen_rd_q    <= 1'b0;
            timeout_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_dtr_q   <= 1'b0;
            pend_iom_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            seen_rd_q    <= seen_rd_d;
            timeout_q    <= timeout_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_dtr_q   <= pend_dtr_d;
            pend_iom_q   <= pend_iom_d;
        end
    end

    // The bus is only ever driven in RD_HOLD during an active read strobe,
    // and never while the CPU itself is writing.
    assign ad_oe = (state_q == RD_HOLD) && !rd_n && wr_n;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ad_drv
            assign ad[gi] = ad_oe ? rdata_q[gi] : 1'bz;
        end
    endgenerate

    // A same-cycle ack keeps ready high so a zero-wait backend never
    // inserts a wait state.
    assign mem_req   = in_req;
    assign mem_we    = (state_q == WR_REQ);
    assign ready     = ~(in_req & ~mem_ack);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_responder_8088.sv
`timescale 1ns/1ps

module tb_bus_responder_8088;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] a;
    wire  [7:0]  ad;
    logic        ale, rd_n, wr_n, dtr, iom;
    logic        ready, mem_req, mem_we, timeout;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic        tb_ad_oe;
    logic [7:0]  tb_ad_val;

    always #5 clk = ~clk;

    // The bench drives address/write data; the bus floats to 8'h00 when
    // nobody drives it, so "released" reads back as zero.
    assign ad = tb_ad_oe ? tb_ad_val : 8'hzz;
    for (genvar gi = 0; gi < 8; gi++) begin : g_pd
        pulldown pd (ad[gi]);
    end

    bus_responder_8088 #(
        .BASE     (20'h00000),
        .MASK     (20'hF0000),
        .IO_SPACE (1'b0),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .ad        (ad),
        .ale       (ale),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .dtr       (dtr),
        .iom       (iom),
        .ready     (ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .timeout   (timeout)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        bit          is_to;
        bit          we;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          req_cyc;
        int          rdy_low;
    } req_exp_t;

    typedef struct {
        int         delay;
        logic [7:0] rdata;
    } bk_t;

    req_exp_t   req_q[$];
    logic [7:0] rd_q[$];
    bk_t        bk_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // ---------------- backend model ----------------
    bk_t cur_bk;
    int  bk_cnt = 0;
    bit  bk_active = 0;

    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack   = 1'b0;
            bk_active = 0;
        end else begin
            if (!bk_active) begin
                bk_active = 1;
                bk_cnt    = 0;
                if (bk_q.size() > 0) cur_bk = bk_q.pop_front();
                else begin
                    cur_bk.delay = 0;
                    cur_bk.rdata = 8'h00;
                end
            end
            if (bk_cnt == cur_bk.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_bk.rdata;
                bk_active = 0;
            end else begin
                mem_ack = 1'b0;
                bk_cnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    int         req_cyc = 0;
    int         rdy_low = 0;
    int         viol    = 0;
    logic       rd_prev = 1'b1;
    logic       rst_prev = 1'b0;
    logic [7:0] last_ad = 8'h00;

    task automatic complete(input bit is_to);
        req_exp_t e;
        if (req_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_%s: got request addr %05h required none",
                     is_to ? "timeout" : "ack", mem_addr);
        end else begin
            e = req_q.pop_front();
            check($sformatf("kind_timeout@%05h", e.addr), 32'(is_to), 32'(e.is_to));
            check($sformatf("mem_addr@%05h", e.addr), 32'(mem_addr), 32'(e.addr));
            if (!is_to) check($sformatf("mem_we@%05h", e.addr), 32'(mem_we), 32'(e.we));
            if (e.we) check($sformatf("mem_wdata@%05h", e.addr), 32'(mem_wdata), 32'(e.wdata));
            check($sformatf("req_cycles@%05h", e.addr), req_cyc, e.req_cyc);
            check($sformatf("ready_low@%05h", e.addr), rdy_low, e.rdy_low);
        end
        req_cyc = 0;
        rdy_low = 0;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (rst_prev) begin
                check("rst_ready", 32'(ready), 32'd1);
                check("rst_mem_req", 32'(mem_req), 32'd0);
                check("rst_mem_we", 32'(mem_we), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
                check("rst_timeout", 32'(timeout), 32'd0);
                if (!tb_ad_oe) check("rst_ad_released", 32'(ad), 32'd0);
            end
            req_cyc = 0;
            rdy_low = 0;
        end else begin
            if (mem_req) req_cyc++;
            if (!ready) rdy_low++;
            if (mem_req && mem_ack) complete(1'b0);
            if (timeout) complete(1'b1);
            if (!tb_ad_oe && rd_n && (ad !== 8'h00)) viol++;
        end
        if (!rd_n) last_ad = ad;
        if (rd_n && !rd_prev) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_read: got ad %02h required no read", last_ad);
            end else begin
                check("rd_data", 32'(last_ad), 32'(rd_q.pop_front()));
            end
        end
        rd_prev  = rd_n;
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    function automatic req_exp_t mk(input bit is_to, input bit we, input logic [19:0] addr,
                                    input logic [7:0] wdata, input int rc, input int rl);
        req_exp_t e;
        e.is_to = is_to; e.we = we; e.addr = addr; e.wdata = wdata;
        e.req_cyc = rc; e.rdy_low = rl;
        return e;
    endfunction

    function automatic bk_t mkbk(input int delay, input logic [7:0] rdata);
        bk_t b;
        b.delay = delay; b.rdata = rdata;
        return b;
    endfunction

    task automatic wait_req_idle(input string name);
        int n = 0;
        #1;
        while (mem_req && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (mem_req) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_wait: mem_req still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic addr_phase(input logic [19:0] addr, input logic is_wr, input logic io);
        @(negedge clk);
        ale = 1'b1; a = addr[19:8]; tb_ad_val = addr[7:0]; tb_ad_oe = 1'b1;
        dtr = is_wr; iom = io;
    endtask

    task automatic do_read(input logic [19:0] addr, input logic io, input string name);
        addr_phase(addr, 1'b0, io);
        @(negedge clk);
        ale = 1'b0; tb_ad_oe = 1'b0; rd_n = 1'b0;
        wait_req_idle(name);
        @(negedge clk);
        rd_n = 1'b1;
    endtask

    task automatic do_write(input logic [19:0] addr, input logic [7:0] data, input string name);
        addr_phase(addr, 1'b1, 1'b0);
        @(negedge clk);
        ale = 1'b0; tb_ad_val = data; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; tb_ad_oe = 1'b0;
        wait_req_idle(name);
    endtask

    initial begin
        rst = 1'b1; a = '0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        dtr = 1'b0; iom = 1'b0; tb_ad_oe = 1'b0; tb_ad_val = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read: ready never low, data on the second rd_n-low cycle.
        bk_q.push_back(mkbk(0, 8'hA5));
        req_q.push_back(mk(0, 0, 20'h01234, 8'h00, 1, 0));
        rd_q.push_back(8'hA5);
        do_read(20'h01234, 1'b0, "rd_01234");

        // Posted write acked 3 cycles late, with a read address phase landing
        // in the pending slot while the write is outstanding.
        bk_q.push_back(mkbk(3, 8'h00));
        bk_q.push_back(mkbk(0, 8'h5A));
        req_q.push_back(mk(0, 1, 20'h00010, 8'h3C, 4, 3));
        req_q.push_back(mk(0, 0, 20'h00020, 8'h00, 1, 0));
        rd_q.push_back(8'h5A);
        addr_phase(20'h00010, 1'b1, 1'b0);
        @(negedge clk);
        ale = 1'b0; tb_ad_val = 8'h3C; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; tb_ad_oe = 1'b0;
        addr_phase(20'h00020, 1'b0, 1'b0);
        @(negedge clk);
        ale = 1'b0; tb_ad_oe = 1'b0; rd_n = 1'b0;
        wait_req_idle("wr_pending");
        @(negedge clk);
        rd_n = 1'b1;

        // Misses: outside the window, and wrong address space.
        rd_q.push_back(8'h00);
        do_read(20'h10000, 1'b0, "miss_window");
        rd_q.push_back(8'h00);
        do_read(20'h01234, 1'b1, "miss_io");

        // No ack: 16 request cycles, one timeout pulse, 0xFF returned.
        bk_q.push_back(mkbk(1000, 8'h00));
        req_q.push_back(mk(1, 0, 20'h02000, 8'h00, 16, 16));
        rd_q.push_back(8'hFF);
        do_read(20'h02000, 1'b0, "rd_timeout");

        // Two consecutive reads across a 4K boundary.
        bk_q.push_back(mkbk(0, 8'h11));
        bk_q.push_back(mkbk(0, 8'h22));
        req_q.push_back(mk(0, 0, 20'h00FFF, 8'h00, 1, 0));
        req_q.push_back(mk(0, 0, 20'h01000, 8'h00, 1, 0));
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        do_read(20'h00FFF, 1'b0, "rd_00FFF");
        do_read(20'h01000, 1'b0, "rd_01000");

        // Reset while in RD_HOLD with rd_n low: bus released at the reset edge.
        bk_q.push_back(mkbk(0, 8'h77));
        req_q.push_back(mk(0, 0, 20'h00100, 8'h00, 1, 0));
        rd_q.push_back(8'h00);
        addr_phase(20'h00100, 1'b0, 1'b0);
        @(negedge clk);
        ale = 1'b0; tb_ad_oe = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; rd_n = 1'b1;

        // Recovery: a zero-wait write after reset.
        bk_q.push_back(mkbk(0, 8'h00));
        req_q.push_back(mk(0, 1, 20'h00200, 8'hC3, 1, 0));
        do_write(20'h00200, 8'hC3, "wr_00200");

        repeat (4) @(negedge clk);
        #3;
        check("req_queue_drained", req_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("backend_queue_drained", bk_q.size(), 32'd0);
        check("ad_driven_with_rd_n_high", viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, required $finish");
        $fatal(1, "watchdog");
    end

endmodule
